bdev_xfer_engine: RTL and testbench

Synthesizable transfer engine that sits directly upstream of the simulated block device. It turns one host-level sector command into the device's req/data/resp handshake sequence. For writes it streams host write beats onto the device data channel; for reads it streams device response beats back to the host. It bounds-checks every command against the device's reported sector count and returns one completion per command.

---
 rtl/bdev_xfer_if.sv | 87 ++++++++
 rtl/bdev_xfer_engine.sv | 161 ++++++++++++++++
 tb/tb_bdev_xfer_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bdev_xfer_if.sv
// Host-side command/data/completion and device-side req/data/resp signals of the transfer engine.
// The engine uses the slave view; the host/device models use the master view.
interface bdev_xfer_if #(
  parameter int DATA_BITS   = 64,
  parameter int SECTOR_BITS = 32,
  parameter int ADDR_BITS   = 32,
  parameter int TAG_BITS    = 1
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [ADDR_BITS-1:0]   cmd_addr;
  logic [SECTOR_BITS-1:0] cmd_offset;
  logic [SECTOR_BITS-1:0] cmd_len;
  logic [TAG_BITS-1:0]    cmd_tag;

  logic                   wdata_valid;
  logic                   wdata_ready;
  logic [DATA_BITS-1:0]   wdata_data;

  logic                   rdata_valid;
  logic                   rdata_ready;
  logic [DATA_BITS-1:0]   rdata_data;

  logic                   done_valid;
  logic                   done_ready;
  logic [TAG_BITS-1:0]    done_tag;
  logic                   done_error;

  logic                   bdev_req_valid;
  logic                   bdev_req_ready;
  logic                   bdev_req_bits_write;
  logic [ADDR_BITS-1:0]   bdev_req_bits_addr;
  logic [SECTOR_BITS-1:0] bdev_req_bits_offset;
  logic [SECTOR_BITS-1:0] bdev_req_bits_len;
  logic [TAG_BITS-1:0]    bdev_req_bits_tag;

  logic                   bdev_data_valid;
  logic                   bdev_data_ready;
  logic [DATA_BITS-1:0]   bdev_data_bits_data;
  logic [TAG_BITS-1:0]    bdev_data_bits_tag;

  logic                   bdev_resp_valid;
  logic                   bdev_resp_ready;
  logic [DATA_BITS-1:0]   bdev_resp_bits_data;
  logic [TAG_BITS-1:0]    bdev_resp_bits_tag;

  logic [SECTOR_BITS-1:0] bdev_info_nsectors;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_offset, cmd_len, cmd_tag,
    output cmd_ready,
    input  wdata_valid, wdata_data,
    output wdata_ready,
    output rdata_valid, rdata_data,
    input  rdata_ready,
    output done_valid, done_tag, done_error,
    input  done_ready,
    output bdev_req_valid, bdev_req_bits_write, bdev_req_bits_addr,
    output bdev_req_bits_offset, bdev_req_bits_len, bdev_req_bits_tag,
    input  bdev_req_ready,
    output bdev_data_valid, bdev_data_bits_data, bdev_data_bits_tag,
    input  bdev_data_ready,
    input  bdev_resp_valid, bdev_resp_bits_data, bdev_resp_bits_tag,
    output bdev_resp_ready,
    input  bdev_info_nsectors
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_offset, cmd_len, cmd_tag,
    input  cmd_ready,
    output wdata_valid, wdata_data,
    input  wdata_ready,
    input  rdata_valid, rdata_data,
    output rdata_ready,
    input  done_valid, done_tag, done_error,
    output done_ready,
    input  bdev_req_valid, bdev_req_bits_write, bdev_req_bits_addr,
    input  bdev_req_bits_offset, bdev_req_bits_len, bdev_req_bits_tag,
    output bdev_req_ready,
    input  bdev_data_valid, bdev_data_bits_data, bdev_data_bits_tag,
    output bdev_data_ready,
    output bdev_resp_valid, bdev_resp_bits_data, bdev_resp_bits_tag,
    input  bdev_resp_ready,
    output bdev_info_nsectors
  );
endinterface

// File: rtl/bdev_xfer_engine.sv
// Turns one host sector command into the block device req/data/resp sequence, one command at a time.
// state | meaning: IDLE wait cmd | REQ issue req | WDATA stream writes | WACK take write ack | RDATA stream reads | DONE completion
module bdev_xfer_engine #(
  parameter int DATA_BITS        = 64,
  parameter int SECTOR_BITS      = 32,
  parameter int ADDR_BITS        = 32,
  parameter int TAG_BITS         = 1,
  parameter int BEATS_PER_SECTOR = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bdev_xfer_if.slave   bus
);
  localparam int BEAT_LOG2 = $clog2(BEATS_PER_SECTOR);
  localparam int CNT_BITS  = SECTOR_BITS + BEAT_LOG2;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WDATA, S_WACK, S_RDATA, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_cmd_ready, r_req_valid, r_done_valid;
  logic                   r_wdata_en, r_rdata_en, r_wack_rdy, r_err;
  logic                   r_write;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [SECTOR_BITS-1:0] r_offset, r_len;
  logic [TAG_BITS-1:0]    r_tag;
  logic [CNT_BITS-1:0]    r_cnt, r_last;

  logic [SECTOR_BITS:0]   w_end;
  logic [CNT_BITS-1:0]    w_total;
  logic                   w_reject, w_cmd_hs, w_req_hs, w_data_hs, w_resp_hs, w_done_hs;
  logic                   w_resp_rdy, w_tag_bad, w_last;

  // End sector is computed one bit wider so offsets near the top cannot wrap past the capacity check.
  assign w_end     = {1'b0, bus.cmd_offset} + {1'b0, bus.cmd_len};
  assign w_total   = CNT_BITS'(bus.cmd_len) << BEAT_LOG2;
  assign w_reject  = (bus.cmd_len == '0) || (w_end > {1'b0, bus.bdev_info_nsectors});
  assign w_resp_rdy = r_wack_rdy | (r_rdata_en & bus.rdata_ready);
  assign w_cmd_hs  = r_cmd_ready & bus.cmd_valid;
  assign w_req_hs  = r_req_valid & bus.bdev_req_ready;
  assign w_data_hs = r_wdata_en & bus.wdata_valid & bus.bdev_data_ready;
  assign w_resp_hs = w_resp_rdy & bus.bdev_resp_valid;
  assign w_done_hs = r_done_valid & bus.done_ready;
  assign w_tag_bad = (bus.bdev_resp_bits_tag != r_tag);
  assign w_last    = (r_cnt == r_last);

  assign bus.cmd_ready            = r_cmd_ready;
  assign bus.bdev_req_valid       = r_req_valid;
  assign bus.bdev_req_bits_write  = r_write;
  assign bus.bdev_req_bits_addr   = r_addr;
  assign bus.bdev_req_bits_offset = r_offset;
  assign bus.bdev_req_bits_len    = r_len;
  assign bus.bdev_req_bits_tag    = r_tag;
  assign bus.bdev_data_valid      = r_wdata_en & bus.wdata_valid;
  assign bus.wdata_ready          = r_wdata_en & bus.bdev_data_ready;
  assign bus.bdev_data_bits_data  = bus.wdata_data;
  assign bus.bdev_data_bits_tag   = r_tag;
  assign bus.rdata_valid          = r_rdata_en & bus.bdev_resp_valid;
  assign bus.rdata_data           = bus.bdev_resp_bits_data;
  assign bus.bdev_resp_ready      = w_resp_rdy;
  assign bus.done_valid           = r_done_valid;
  assign bus.done_tag             = r_tag;
  assign bus.done_error           = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_req_valid  <= 1'b0;
      r_done_valid <= 1'b0;
      r_wdata_en   <= 1'b0;
      r_rdata_en   <= 1'b0;
      r_wack_rdy   <= 1'b0;
      r_err        <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_offset     <= '0;
      r_len        <= '0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_last       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            r_write     <= bus.cmd_write;
            r_addr      <= bus.cmd_addr;
            r_offset    <= bus.cmd_offset;
            r_len       <= bus.cmd_len;
            r_tag       <= bus.cmd_tag;
            r_cnt       <= '0;
            r_last      <= w_total - CNT_ONE;
            if (w_reject) begin
              r_err        <= 1'b1;
              r_done_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end else begin
            // cmd_ready rises one edge after reset release, never during reset
            r_cmd_ready <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_req_hs) begin
            r_req_valid <= 1'b0;
            if (r_write) begin
              r_wdata_en <= 1'b1;
              r_state    <= S_WDATA;
            end else begin
              r_rdata_en <= 1'b1;
              r_state    <= S_RDATA;
            end
          end
        end
        S_WDATA: begin
          if (w_data_hs) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_last) begin
              r_wdata_en <= 1'b0;
              r_wack_rdy <= 1'b1;
              r_state    <= S_WACK;
            end
          end
        end
        S_WACK: begin
          if (w_resp_hs) begin
            r_wack_rdy   <= 1'b0;
            r_err        <= r_err | w_tag_bad;
            r_done_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_RDATA: begin
          if (w_resp_hs) begin
            r_cnt <= r_cnt + CNT_ONE;
            r_err <= r_err | w_tag_bad;
            if (w_last) begin
              r_rdata_en   <= 1'b0;
              r_done_valid <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_done_hs) begin
            r_done_valid <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bdev_xfer_engine.sv
// Self-checking bench for bdev_xfer_engine: table of commands driven through host and device models,
// with beat scoreboards, completion timing checks and a mid-transfer reset sequence.
module tb_bdev_xfer_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bdev_xfer_if #(.DATA_BITS(64), .SECTOR_BITS(32), .ADDR_BITS(32), .TAG_BITS(1)) bus ();

  bdev_xfer_engine #(
    .DATA_BITS(64), .SECTOR_BITS(32), .ADDR_BITS(32), .TAG_BITS(1), .BEATS_PER_SECTOR(64)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [31:0] len;
    logic [31:0] ns;
    logic        tag;
    bit          rnd;
    int          bad;    // read: beat index with wrong tag; write: 0 = ack with wrong tag
    int          stall;  // cycles bdev_req_ready is held low
    int          abort;  // read beat index at which reset is asserted, -1 = none
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int s, input int i);
    logic [31:0] sv;
    logic [31:0] iv;
    sv = s;
    iv = i;
    return {sv[15:0] ^ 16'h5A5A, 16'hC0DE, iv};
  endfunction

  task automatic clear_inputs();
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_offset = 0;
    bus.cmd_len = 0; bus.cmd_tag = 0;
    bus.wdata_valid = 0; bus.wdata_data = 0; bus.rdata_ready = 0; bus.done_ready = 0;
    bus.bdev_req_ready = 0; bus.bdev_data_ready = 0;
    bus.bdev_resp_valid = 0; bus.bdev_resp_bits_data = 0; bus.bdev_resp_bits_tag = 0;
  endtask

  task automatic run_cmd(input vec_t v, input int seed);
    logic        rej;
    logic [31:0] addr;
    logic [63:0] e;
    logic [63:0] q[$];
    int beats, cyc, last_cyc, stall_cnt, host_i, dev_i, rd_i, acks;
    int n_early, n_crdy, n_req;
    bit req_pend, req_done, done_seen, aborted;

    rej   = (v.len == 0) || (({1'b0, v.off} + {1'b0, v.len}) > {1'b0, v.ns});
    beats = rej ? 0 : int'(v.len) * 64;
    addr  = 32'h8000_0000 | seed;
    cyc = 0; last_cyc = rej ? -1 : -100; stall_cnt = 0; host_i = 0; dev_i = 0; rd_i = 0;
    acks = 0; n_early = 0; n_crdy = 0; n_req = 0;
    req_pend = 0; req_done = 0; done_seen = 0; aborted = 0;

    @(negedge clk);
    bus.bdev_info_nsectors = v.ns;
    bus.cmd_valid = 1; bus.cmd_write = v.wr; bus.cmd_addr = addr;
    bus.cmd_offset = v.off; bus.cmd_len = v.len; bus.cmd_tag = v.tag;
    #1 chk("cmd_ready_idle", bus.cmd_ready, 1);

    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      bus.cmd_valid = 0;
      if (req_pend) req_done = 1;
      bus.bdev_req_ready = (stall_cnt >= v.stall);
      bus.done_ready = 1;
      if (v.wr) begin
        bus.wdata_valid     = (host_i < beats) && (v.rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
        bus.wdata_data      = pat(seed, host_i);
        bus.bdev_data_ready = v.rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
        bus.bdev_resp_valid = (acks == 0);
        bus.bdev_resp_bits_data = 64'hDEAD_BEEF_0000_0000;
        bus.bdev_resp_bits_tag  = (v.bad == 0) ? ~v.tag : v.tag;
      end else begin
        bus.bdev_resp_valid = (dev_i < beats) && (v.rnd ? ($urandom_range(1, 0) == 1) : 1'b1);
        bus.bdev_resp_bits_data = pat(seed, dev_i);
        bus.bdev_resp_bits_tag  = (dev_i == v.bad) ? ~v.tag : v.tag;
        bus.rdata_ready = v.rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      end
      #1;
      if (v.abort >= 0 && dev_i == v.abort) begin
        rst_n = 0;
        #1;
        chk("abort_rdata_valid", bus.rdata_valid, 0);
        chk("abort_resp_ready", bus.bdev_resp_ready, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 0);
        chk("abort_done_valid", bus.done_valid, 0);
        chk("abort_req_valid", bus.bdev_req_valid, 0);
        aborted = 1;
        break;
      end
      if (bus.cmd_ready) n_crdy++;
      if (bus.bdev_req_valid) begin
        n_req++;
        chk("req_write", bus.bdev_req_bits_write, v.wr);
        chk("req_addr", bus.bdev_req_bits_addr, addr);
        chk("req_offset", bus.bdev_req_bits_offset, v.off);
        chk("req_len", bus.bdev_req_bits_len, v.len);
        chk("req_tag", bus.bdev_req_bits_tag, v.tag);
        if (bus.bdev_req_ready) req_pend = 1;
        stall_cnt++;
      end
      if (v.wr) begin
        if (bus.wdata_valid && bus.wdata_ready) begin
          q.push_back(pat(seed, host_i));
          host_i++;
        end
        if (bus.bdev_data_valid && bus.bdev_data_ready) begin
          if (q.size() == 0) chk("wbeat_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("wbeat_data", bus.bdev_data_bits_data, e);
          end
          chk("wbeat_tag", bus.bdev_data_bits_tag, v.tag);
          dev_i++;
        end
        if (bus.bdev_resp_valid && bus.bdev_resp_ready) begin
          if (dev_i < beats || acks > 0) n_early++;
          acks++;
          last_cyc = cyc;
        end
      end else begin
        if (bus.bdev_resp_valid && bus.bdev_resp_ready) begin
          if (!req_done) n_early++;
          q.push_back(pat(seed, dev_i));
          dev_i++;
          if (dev_i == beats) last_cyc = cyc;
        end
        if (bus.rdata_valid && bus.rdata_ready) begin
          if (q.size() == 0) chk("rbeat_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("rbeat_data", bus.rdata_data, e);
          end
          rd_i++;
        end
      end
      if (bus.done_valid) begin
        done_seen = 1;
        chk("done_cycle", 64'(cyc), 64'(last_cyc + 1));
        chk("done_tag", bus.done_tag, v.tag);
        chk("done_error", bus.done_error, v.exp_err);
      end
      cyc++;
    end

    if (aborted) begin
      clear_inputs();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      #1 chk("abort_cmd_ready_release", bus.cmd_ready, 0);
      n_req = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1 if (bus.done_valid) n_req++;
      end
      chk("abort_no_done", 64'(n_req), 0);
      chk("abort_cmd_ready_after", bus.cmd_ready, 1);
      return;
    end

    if (!done_seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("cmd_ready_after_done", bus.cmd_ready, 1);
    chk("done_valid_after_done", bus.done_valid, 0);
    chk(v.wr ? "wbeat_count" : "rbeat_count", 64'(v.wr ? dev_i : rd_i), 64'(beats));
    chk("ack_count", 64'(acks), (v.wr && !rej) ? 64'd1 : 64'd0);
    chk("early_resp", 64'(n_early), 0);
    chk("cmd_ready_busy", 64'(n_crdy), 0);
    chk("req_cycles", 64'(n_req), rej ? 64'd0 : 64'(v.stall + 1));
  endtask

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    off            len    ns             tag   rnd bad stall abort err
    tbl[0]  = '{1'b0, 32'd2,         32'd1, 32'd8,         1'b1, 0, -1, 0,   -1,   1'b0};
    tbl[1]  = '{1'b1, 32'd0,         32'd2, 32'd8,         1'b0, 1, -1, 0,   -1,   1'b0};
    tbl[2]  = '{1'b0, 32'd7,         32'd2, 32'd8,         1'b0, 0, -1, 0,   -1,   1'b1};
    tbl[3]  = '{1'b1, 32'd0,         32'd0, 32'd8,         1'b1, 0, -1, 0,   -1,   1'b1};
    tbl[4]  = '{1'b0, 32'd0,         32'd1, 32'd8,         1'b0, 0, 10, 0,   -1,   1'b1};
    tbl[5]  = '{1'b0, 32'd1,         32'd1, 32'd4,         1'b1, 1, -1, 5,   -1,   1'b0};
    tbl[6]  = '{1'b1, 32'd3,         32'd1, 32'd0,         1'b0, 0, -1, 0,   -1,   1'b1};
    tbl[7]  = '{1'b1, 32'd7,         32'd1, 32'd8,         1'b1, 0, -1, 2,   -1,   1'b0};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, -1, 0,   -1,   1'b1};
    tbl[9]  = '{1'b1, 32'd0,         32'd1, 32'd8,         1'b1, 0, 0,  0,   -1,   1'b1};
    tbl[10] = '{1'b0, 32'd0,         32'd1, 32'd8,         1'b1, 0, -1, 0,   20,   1'b0};
    tbl[11] = '{1'b0, 32'd4,         32'd1, 32'd8,         1'b0, 0, -1, 0,   -1,   1'b0};

    clear_inputs();
    bus.bdev_info_nsectors = 32'd8;
    #2;
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_req_valid", bus.bdev_req_valid, 0);
    chk("reset_done_valid", bus.done_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 chk("release_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    #1 chk("first_edge_cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 12; i++) run_cmd(tbl[i], i + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
